// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one uart transmitter between byte sources
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int ID_W          = 2,
  parameter int START_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_byte,
  output logic [NUM_REQ-1:0]   ack,
  output logic                 uart_transmit,
  output logic [7:0]           uart_tx_byte,
  input  logic                 uart_is_transmitting,
  output logic                 busy,
  output logic [ID_W-1:0]      active_id,
  output logic                 start_error
);

  localparam int CNT_W = $clog2(START_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e             state_q;
  logic [NUM_REQ-1:0] ack_q;
  logic               transmit_q;
  logic [7:0]         tx_byte_q;
  logic               busy_q;
  logic [ID_W-1:0]    active_id_q;
  logic               start_error_q;
  logic [ID_W-1:0]    rr_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               sel_vld_d;
  logic [ID_W-1:0]    sel_id_d;
  logic [7:0]         sel_byte_d;
  logic [ID_W-1:0]    rr_d;

  // Scan offsets from the highest down so the requester nearest the pointer wins.
  always_comb begin
    int idx;
    idx        = 0;
    sel_vld_d  = 1'b0;
    sel_id_d   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(rr_q) + k) % NUM_REQ;
      if (req[idx]) begin
        sel_vld_d = 1'b1;
        sel_id_d  = ID_W'(idx);
      end
    end
    sel_byte_d = req_byte[8*int'(sel_id_d) +: 8];
    rr_d       = ID_W'((int'(sel_id_d) + 1) % NUM_REQ);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      ack_q         <= '0;
      transmit_q    <= 1'b0;
      tx_byte_q     <= 8'h00;
      busy_q        <= 1'b0;
      active_id_q   <= '0;
      start_error_q <= 1'b0;
      rr_q          <= '0;
      cnt_q         <= '0;
    end else begin
      ack_q         <= '0;
      start_error_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // Holding off while the uart is busy covers a reset that landed mid-frame.
          if (sel_vld_d && !uart_is_transmitting) begin
            tx_byte_q   <= sel_byte_d;
            ack_q       <= NUM_REQ'(1) << sel_id_d;
            active_id_q <= sel_id_d;
            rr_q        <= rr_d;
            transmit_q  <= 1'b1;
            cnt_q       <= '0;
            busy_q      <= 1'b1;
            state_q     <= START;
          end
        end
        START: begin
          if (uart_is_transmitting) begin
            transmit_q <= 1'b0;
            state_q    <= DRAIN;
          end else if (cnt_q == CNT_W'(START_TIMEOUT - 1)) begin
            transmit_q    <= 1'b0;
            start_error_q <= 1'b1;
            busy_q        <= 1'b0;
            state_q       <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DRAIN: begin
          if (!uart_is_transmitting) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          transmit_q <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign ack           = ack_q;
  assign uart_transmit = transmit_q;
  assign uart_tx_byte  = tx_byte_q;
  assign busy          = busy_q;
  assign active_id     = active_id_q;
  assign start_error   = start_error_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter with a behavioural uart handshake model
module tb_uart_tx_arbiter;

  localparam int FRAME_LEN = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] req_byte = '0;
  logic [3:0]  ack;
  logic        uart_transmit;
  logic [7:0]  uart_tx_byte;
  logic        uart_is_transmitting;
  logic        busy;
  logic [1:0]  active_id;
  logic        start_error;

  logic        model_en = 1'b0;
  logic        model_tx = 1'b0;
  logic        forced_tx = 1'b0;
  int          mstate = 0;
  int          mcnt = 0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] data;
    logic [1:0] id;
  } exp_t;
  exp_t exp_q[$];
  exp_t e_m;

  assign uart_is_transmitting = model_en ? model_tx : forced_tx;

  uart_tx_arbiter #(
    .NUM_REQ(4),
    .ID_W(2),
    .START_TIMEOUT(5)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .req_byte(req_byte),
    .ack(ack),
    .uart_transmit(uart_transmit),
    .uart_tx_byte(uart_tx_byte),
    .uart_is_transmitting(uart_is_transmitting),
    .busy(busy),
    .active_id(active_id),
    .start_error(start_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] data, input logic [1:0] id);
    exp_t e;
    e.data = data;
    e.id   = id;
    exp_q.push_back(e);
  endtask

  task automatic wait_pop(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("wait_pop_timeout", 32'(exp_q.size()), 0);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (!(mstate == 0 && busy == 1'b0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("wait_idle_timeout", 32'(n < budget), 1);
  endtask

  // uart stand-in: accept a frame on transmit, hold is_transmitting, then recover once transmit is low
  always @(negedge clk) begin
    if (!model_en || !rst_n) begin
      mstate   = 0;
      mcnt     = 0;
      model_tx = 1'b0;
    end else if (mstate == 0) begin
      if (uart_transmit) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_frame", 32'(uart_tx_byte), 32'hFFFF);
        end else begin
          e_m = exp_q.pop_front();
          chk("tx_byte", 32'(uart_tx_byte), 32'(e_m.data));
          chk("active_id", 32'(active_id), 32'(e_m.id));
          chk("ack_grant", 32'(ack), 32'(1) << e_m.id);
        end
        model_tx = 1'b1;
        mcnt     = 0;
        mstate   = 1;
      end
    end else if (mstate == 1) begin
      mcnt++;
      chk("transmit_in_recover", 32'(uart_transmit), 0);
      if (mcnt == 1) chk("ack_one_cycle", 32'(ack), 0);
      if (mcnt == FRAME_LEN) begin
        model_tx = 1'b0;
        mstate   = 2;
      end
    end else begin
      chk("busy_after_drain", 32'(busy), 0);
      mstate = 0;
    end
  end

  initial begin
    int hi;
    int se;
    logic [3:0] ackv;

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_transmit", 32'(uart_transmit), 0);
    chk("rst_tx_byte", 32'(uart_tx_byte), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_active_id", 32'(active_id), 0);
    chk("rst_start_error", 32'(start_error), 0);
    rst_n    = 1'b1;
    model_en = 1'b1;
    @(negedge clk);

    // single requester
    req_byte[15:8] = 8'hA5;
    push(8'hA5, 2'd1);
    req = 4'b0010;
    wait_pop(20);
    req = 4'b0000;
    wait_idle(30);

    // round robin from a fresh pointer
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    req_byte = 32'h13121110;
    push(8'h10, 2'd0);
    push(8'h11, 2'd1);
    push(8'h12, 2'd2);
    push(8'h13, 2'd3);
    push(8'h10, 2'd0);
    req = 4'b1111;
    wait_pop(100);
    req = 4'b0000;
    wait_idle(30);

    // grant to 3 alone, then wrap and skip over 1 and 3
    req_byte = 32'h33001100;
    push(8'h33, 2'd3);
    req = 4'b1000;
    wait_pop(20);
    req = 4'b0000;
    wait_idle(30);
    req_byte = 32'h33520050;
    push(8'h50, 2'd0);
    push(8'h52, 2'd2);
    push(8'h50, 2'd0);
    req = 4'b0101;
    wait_pop(80);
    req = 4'b0000;
    wait_idle(30);

    // start timeout with a silent uart; pointer sits at 1 so requester 2 wins
    model_en  = 1'b0;
    forced_tx = 1'b0;
    req_byte  = 32'h33220000;
    req       = 4'b0100;
    hi = 0;
    se = 0;
    ackv = '0;
    repeat (20) begin
      @(negedge clk);
      if (uart_transmit) hi++;
      if (start_error) se++;
      if (ack != 4'b0000) begin
        ackv = ack;
        req  = 4'b0000;
      end
    end
    chk("timeout_transmit_cycles", 32'(hi), 5);
    chk("timeout_error_pulses", 32'(se), 1);
    chk("timeout_ack", 32'(ackv), 32'h4);
    chk("timeout_busy", 32'(busy), 0);
    model_en = 1'b1;
    @(negedge clk);
    push(8'h33, 2'd3);
    req = 4'b1101;
    wait_pop(20);
    req = 4'b0000;
    wait_idle(30);

    // reset landing in DRAIN while the uart is still mid-frame
    req_byte = 32'h000000A0;
    push(8'hA0, 2'd0);
    req = 4'b0001;
    wait_pop(20);
    repeat (2) @(negedge clk);
    chk("pre_reset_busy", 32'(busy), 1);
    forced_tx = 1'b1;
    model_en  = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_transmit", 32'(uart_transmit), 0);
    chk("async_rst_busy", 32'(busy), 0);
    chk("async_rst_ack", 32'(ack), 0);
    chk("async_rst_tx_byte", 32'(uart_tx_byte), 0);
    chk("async_rst_active_id", 32'(active_id), 0);
    @(negedge clk);
    rst_n = 1'b1;
    ackv = '0;
    repeat (5) begin
      @(negedge clk);
      ackv = ackv | ack;
    end
    chk("no_grant_while_uart_busy", 32'(ackv), 0);
    forced_tx = 1'b0;
    @(negedge clk);
    chk("post_reset_ack", 32'(ack), 32'h1);
    chk("post_reset_transmit", 32'(uart_transmit), 1);
    chk("post_reset_tx_byte", 32'(uart_tx_byte), 32'hA0);
    req = 4'b0000;
    repeat (8) @(negedge clk);
    chk("final_busy", 32'(busy), 0);
    chk("scoreboard_empty", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
